// File: rtl/apb_master.sv
// APB master bridge: one local command at a time becomes a SETUP/ACCESS transfer,
// with an optional wait-state timeout and a held response handshake.
module apb_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Count value held during the last permitted wait cycle; a low pready here aborts.
  localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              psel_nxt, penable_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              load_cmd;
  logic              timeout_hit;

  assign cmd_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYC > 0) && !pready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    psel_nxt        = psel;
    penable_nxt     = penable;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    rsp_rdata_nxt   = rsp_rdata;
    load_cmd        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd    = 1'b1;
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
      end
      ACCESS: begin
        // Completion wins over timeout when pready rises on the final allowed cycle.
        if (pready) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB and response outputs; address/direction/data load only on acceptance.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      if (load_cmd) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, APB address width.
REQ-002 The block SHALL take parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL take parameter TIMEOUT_CYC, default 16, the maximum number of ACCESS cycles with pready low; 0 disables the timeout.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- pclk  in  1  single clock; all logic rising-edge.
- presetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  local command request.
- cmd_ready  out  1  block accepts a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  local side takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Function
REQ-005 The FSM SHALL have four states, IDLE, SETUP, ACCESS and RESP, and all APB and rsp_* outputs SHALL be registered.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-007 On acceptance, cmd_addr, cmd_write and cmd_wdata SHALL be latched, and the FSM SHALL go to SETUP on the next edge.
REQ-008 In SETUP, psel SHALL be 1 and penable SHALL be 0; the next state SHALL always be ACCESS.
REQ-009 In ACCESS, psel SHALL be 1 and penable SHALL be 1; the FSM SHALL stay in ACCESS while pready is 0.
REQ-010 paddr, pwrite and pwdata SHALL hold the latched values, stable from SETUP through the final ACCESS cycle.
REQ-011 Outside SETUP and ACCESS, paddr, pwrite and pwdata SHALL hold their last values.
REQ-012 In ACCESS with pready=1, the block SHALL capture the response and go to RESP:
- rsp_rdata = prdata for a read, 0 for a write.
- rsp_err = pslverr.
- rsp_timeout = 0.
- psel and penable SHALL be 0 on the next cycle.
REQ-013 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-014 If TIMEOUT_CYC>0 and the wait counter reaches TIMEOUT_CYC with pready still 0, the block SHALL abort the transfer:
- psel and penable SHALL drop.
- rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- The FSM SHALL go to RESP.
REQ-015 The wait counter SHALL be wide enough for TIMEOUT_CYC without wrap; a pready=1 on the cycle the count is reached SHALL take priority as a normal completion.
REQ-016 In RESP, rsp_valid SHALL be 1 and rsp_* SHALL be stable until rsp_ready=1; the FSM SHALL then return to IDLE with rsp_valid=0 next cycle.
REQ-017 Latency with zero wait states: command accepted at edge N gives psel at N+1, penable at N+2, rsp_valid at N+3; each wait state adds one cycle.
REQ-018 A cmd_valid held while busy SHALL wait without loss; back-to-back commands SHALL have at least one IDLE cycle between them.
REQ-019 pslverr and prdata SHALL be ignored except in ACCESS with pready=1.

Reset
REQ-020 While presetn=0, the FSM SHALL be in IDLE and all outputs SHALL be 0 except cmd_ready, which SHALL be 1.
REQ-021 Reset asserted mid-transfer SHALL immediately drop psel, penable and rsp_valid; no response SHALL be produced for the aborted command.

Verification
REQ-022 Write 0x04, 0xDEADBEEF, pready=1 from the first ACCESS cycle -> SETUP then 1 ACCESS cycle with paddr=0x04, pwrite=1, pwdata=0xDEADBEEF; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-023 Read 0x08, pready low for 3 ACCESS cycles, prdata=0x12345678 -> 4 ACCESS cycles; rsp_rdata=0x12345678 and rsp_valid at N+6.
REQ-024 Read with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0.
REQ-025 TIMEOUT_CYC=16 with pready held 0 -> psel drops after 16 wait cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 Hold rsp_ready=0 for 5 cycles in RESP with cmd_valid high -> rsp_* stable and cmd_ready=0; after rsp_ready=1 and one IDLE cycle the next command is accepted.
REQ-027 Assert presetn=0 in ACCESS -> psel=0, penable=0 and rsp_valid=0 immediately; after release, cmd_ready=1 and a new read completes normally.
